// File: rtl/fifo_flags_if.sv
// Handshake and status bundle for fifo_flags: the controller side drives requests,
// the FIFO side returns read data and occupancy flags.
interface fifo_flags_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  enb;
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic                  pausa;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  full;
    logic                  almost_full;
    logic                  empty;
    logic                  almost_empty;
    logic                  error_full;

    modport master (
        output enb, push, data_in, pop, pausa,
        input  data_out, valid_out, full, almost_full, empty, almost_empty, error_full
    );

    modport slave (
        input  enb, push, data_in, pop, pausa,
        output data_out, valid_out, full, almost_full, empty, almost_empty, error_full
    );
endinterface

// File: rtl/fifo_flags.sv
// Synchronous FIFO with registered read port, occupancy flags and a sticky
// overflow indicator. Flags decode only the registered count.
module fifo_flags #(
    parameter int DATA_WIDTH      = 6,
    parameter int ADDR_WIDTH      = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fifo_flags_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DepthCnt   = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AlmFullCnt = ALMOST_FULL_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AlmEmptCnt = ALMOST_EMPTY_TH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wrPtr;
    logic [ADDR_WIDTH-1:0] rdPtr;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  validOut;
    logic                  errorFull;

    logic popAcc;
    logic pushAcc;
    logic isFull;
    logic isEmpty;

    // Accept decisions; a push into a full FIFO is only legal when a pop frees a slot.
    always_comb begin
        isFull  = (count == DepthCnt);
        isEmpty = (count == '0);
        popAcc  = bus.enb & bus.pop & ~bus.pausa & ~isEmpty;
        pushAcc = bus.enb & bus.push & (~isFull | popAcc);
    end

    // Storage array; contents are not reset, stale words are unreachable after reset.
    always_ff @(posedge clk) begin
        if (!rst && pushAcc) begin
            mem[wrPtr] <= bus.data_in;
        end
    end

    // Pointers, occupancy, read register and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            dataOut   <= '0;
            validOut  <= 1'b0;
            errorFull <= 1'b0;
        end else begin
            // popAcc already includes enb, so a disabled cycle forces this low.
            validOut <= popAcc;
            if (pushAcc) begin
                wrPtr <= wrPtr + ADDR_WIDTH'(1);
            end
            if (popAcc) begin
                dataOut <= mem[rdPtr];
                rdPtr   <= rdPtr + ADDR_WIDTH'(1);
            end
            unique case ({pushAcc, popAcc})
                2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
                default: count <= count;
            endcase
            if (bus.enb && bus.push && !pushAcc) begin
                errorFull <= 1'b1;
            end
        end
    end

    // Status outputs straight from registered state.
    always_comb begin
        bus.data_out     = dataOut;
        bus.valid_out    = validOut;
        bus.full         = isFull;
        bus.empty        = isEmpty;
        bus.almost_full  = (count >= AlmFullCnt);
        bus.almost_empty = (count <= AlmEmptCnt);
        bus.error_full   = errorFull;
    end
endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench for fifo_flags: each task drives one scenario and checks inline.
module tb_fifo_flags;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nChecks = 0;
    int   nFail = 0;

    fifo_flags_if #(.DATA_WIDTH(6)) bus ();

    fifo_flags #(
        .DATA_WIDTH(6),
        .ADDR_WIDTH(3),
        .ALMOST_FULL_TH(6),
        .ALMOST_EMPTY_TH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Flag vector order: {empty, almost_empty, almost_full, full, error_full}
    function automatic logic [4:0] flags();
        return {bus.empty, bus.almost_empty, bus.almost_full, bus.full, bus.error_full};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.pausa = 1'b0;
        bus.enb = 1'b1;
        bus.data_in = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic fill(input int first, input int n);
        bus.push = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.data_in = 6'(first + i);
            tick();
        end
        bus.push = 1'b0;
    endtask

    task automatic test_reset();
        bus.enb = 1'b0;
        bus.push = 1'b1;
        bus.pop = 1'b1;
        bus.pausa = 1'b0;
        bus.data_in = 6'h15;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        nChecks++;
        if (flags() !== 5'b11000) begin
            nFail++;
            $display("FAIL reset flags: got %b expected %b", flags(), 5'b11000);
        end
        nChecks++;
        if (bus.valid_out !== 1'b0 || bus.data_out !== 6'd0) begin
            nFail++;
            $display("FAIL reset outputs: got valid=%b data=%0d expected valid=0 data=0",
                     bus.valid_out, bus.data_out);
        end
    endtask

    task automatic test_fill();
        logic [4:0] expFlags [8];
        expFlags = '{5'b01000, 5'b01000, 5'b00000, 5'b00000,
                     5'b00000, 5'b00100, 5'b00100, 5'b00110};
        do_reset();
        bus.push = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.data_in = 6'(i + 1);
            tick();
            nChecks++;
            if (flags() !== expFlags[i]) begin
                nFail++;
                $display("FAIL fill flags after push %0d: got %b expected %b",
                         i + 1, flags(), expFlags[i]);
            end
        end
        bus.push = 1'b0;
    endtask

    task automatic test_overflow();
        // Continues from the full FIFO holding 1..8.
        bus.push = 1'b1;
        bus.data_in = 6'd9;
        tick();
        bus.push = 1'b0;
        nChecks++;
        if (flags() !== 5'b00111) begin
            nFail++;
            $display("FAIL overflow flags: got %b expected %b", flags(), 5'b00111);
        end
        tick();
        nChecks++;
        if (bus.error_full !== 1'b1) begin
            nFail++;
            $display("FAIL overflow sticky: got %b expected 1", bus.error_full);
        end
        bus.pop = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            nChecks++;
            if (bus.valid_out !== 1'b1 || bus.data_out !== 6'(i)) begin
                nFail++;
                $display("FAIL overflow drain %0d: got valid=%b data=%0d expected valid=1 data=%0d",
                         i, bus.valid_out, bus.data_out, i);
            end
        end
        tick();
        bus.pop = 1'b0;
        nChecks++;
        if (bus.valid_out !== 1'b0 || bus.data_out !== 6'd8 || flags() !== 5'b11001) begin
            nFail++;
            $display("FAIL overflow after drain: got valid=%b data=%0d flags=%b expected 0 8 11001",
                     bus.valid_out, bus.data_out, flags());
        end
    endtask

    task automatic test_full_push_pop();
        logic [5:0] expData [8];
        expData = '{6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'h2A};
        do_reset();
        fill(1, 8);
        bus.push = 1'b1;
        bus.pop = 1'b1;
        bus.data_in = 6'h2A;
        tick();
        bus.push = 1'b0;
        nChecks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 6'd1 || flags() !== 5'b00110) begin
            nFail++;
            $display("FAIL fullpp same cycle: got valid=%b data=%0d flags=%b expected 1 1 00110",
                     bus.valid_out, bus.data_out, flags());
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            nChecks++;
            if (bus.valid_out !== 1'b1 || bus.data_out !== expData[i]) begin
                nFail++;
                $display("FAIL fullpp drain %0d: got valid=%b data=%0d expected valid=1 data=%0d",
                         i, bus.valid_out, bus.data_out, expData[i]);
            end
        end
        bus.pop = 1'b0;
        nChecks++;
        if (flags() !== 5'b11000) begin
            nFail++;
            $display("FAIL fullpp end flags: got %b expected %b", flags(), 5'b11000);
        end
    endtask

    task automatic test_pausa();
        do_reset();
        fill(10, 3);
        bus.pop = 1'b1;
        bus.pausa = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            nChecks++;
            if (bus.valid_out !== 1'b0 || flags() !== 5'b00000) begin
                nFail++;
                $display("FAIL pausa hold %0d: got valid=%b flags=%b expected 0 00000",
                         i, bus.valid_out, flags());
            end
        end
        bus.pausa = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            nChecks++;
            if (bus.valid_out !== 1'b1 || bus.data_out !== 6'(10 + i)) begin
                nFail++;
                $display("FAIL pausa release %0d: got valid=%b data=%0d expected valid=1 data=%0d",
                         i, bus.valid_out, bus.data_out, 10 + i);
            end
        end
        tick();
        bus.pop = 1'b0;
        nChecks++;
        if (bus.valid_out !== 1'b0 || flags() !== 5'b11000) begin
            nFail++;
            $display("FAIL pausa pop empty: got valid=%b flags=%b expected 0 11000",
                     bus.valid_out, flags());
        end
    endtask

    task automatic test_empty_push_pop();
        do_reset();
        bus.push = 1'b1;
        bus.pop = 1'b1;
        bus.data_in = 6'd5;
        tick();
        bus.push = 1'b0;
        nChecks++;
        if (bus.valid_out !== 1'b0 || flags() !== 5'b01000) begin
            nFail++;
            $display("FAIL emptypp same cycle: got valid=%b flags=%b expected 0 01000",
                     bus.valid_out, flags());
        end
        tick();
        bus.pop = 1'b0;
        nChecks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 6'd5 || flags() !== 5'b11000) begin
            nFail++;
            $display("FAIL emptypp pop: got valid=%b data=%0d flags=%b expected 1 5 11000",
                     bus.valid_out, bus.data_out, flags());
        end
    endtask

    task automatic test_enable();
        do_reset();
        fill(33, 2);
        bus.pop = 1'b1;
        tick();
        // enb low: push, pop and overflow attempts must all be frozen out.
        bus.enb = 1'b0;
        bus.push = 1'b1;
        bus.data_in = 6'd60;
        tick();
        nChecks++;
        if (bus.valid_out !== 1'b0 || bus.data_out !== 6'd33 || flags() !== 5'b01000) begin
            nFail++;
            $display("FAIL enable freeze: got valid=%b data=%0d flags=%b expected 0 33 01000",
                     bus.valid_out, bus.data_out, flags());
        end
        bus.push = 1'b0;
        bus.enb = 1'b1;
        tick();
        bus.pop = 1'b0;
        nChecks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 6'd34 || flags() !== 5'b11000) begin
            nFail++;
            $display("FAIL enable resume: got valid=%b data=%0d flags=%b expected 1 34 11000",
                     bus.valid_out, bus.data_out, flags());
        end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        // Set the sticky flag first so the final reset has something to clear.
        fill(1, 9);
        bus.pop = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        bus.pop = 1'b0;
        fill(20, 1);
        bus.push = 1'b1;
        bus.pop = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.data_in = 6'(21 + i);
            tick();
            nChecks++;
            if (bus.valid_out !== 1'b1 || bus.data_out !== 6'(20 + i) || bus.empty !== 1'b0) begin
                nFail++;
                $display("FAIL wrap pair %0d: got valid=%b data=%0d empty=%b expected 1 %0d 0",
                         i, bus.valid_out, bus.data_out, bus.empty, 20 + i);
            end
        end
        bus.push = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.pop = 1'b0;
        nChecks++;
        if (bus.valid_out !== 1'b0 || bus.data_out !== 6'd0 || flags() !== 5'b11000) begin
            nFail++;
            $display("FAIL wrap reset: got valid=%b data=%0d flags=%b expected 0 0 11000",
                     bus.valid_out, bus.data_out, flags());
        end
        tick();
        nChecks++;
        if (bus.valid_out !== 1'b0 || bus.empty !== 1'b1) begin
            nFail++;
            $display("FAIL wrap post reset: got valid=%b empty=%b expected 0 1",
                     bus.valid_out, bus.empty);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_fill();
        test_overflow();
        test_full_push_pop();
        test_pausa();
        test_empty_push_pop();
        test_enable();
        test_wrap_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/fifo_flags.md
FIFO_FLAGS -- requirements
Module: fifo_flags

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 6, word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, log2 of depth (depth = 8).
REQ-003 SHALL have parameter ALMOST_FULL_TH, default 6, occupancy at or above which almost_full asserts.
REQ-004 SHALL have parameter ALMOST_EMPTY_TH, default 2, occupancy at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 enb  input  1  block enable; low freezes all state.
REQ-008 push  input  1  write request.
REQ-009 data_in  input  DATA_WIDTH  write data.
REQ-010 pop  input  1  read request.
REQ-011 pausa  input  1  flow-control pause from the controller; high blocks reads.
REQ-012 data_out  output  DATA_WIDTH  registered read data.
REQ-013 valid_out  output  1  data_out carries a newly popped word this cycle.
REQ-014 full  output  1  occupancy == depth.
REQ-015 almost_full  output  1  occupancy >= ALMOST_FULL_TH.
REQ-016 empty  output  1  occupancy == 0.
REQ-017 almost_empty  output  1  occupancy <= ALMOST_EMPTY_TH.
REQ-018 error_full  output  1  sticky overflow indicator.

Function
REQ-019 SHALL keep write pointer, read pointer (ADDR_WIDTH bits, wrap modulo depth), and occupancy count (ADDR_WIDTH+1 bits).
REQ-020 Push accepted iff enb & push & (!full | pop_accepted); accepted push writes data_in at write pointer and increments it.
REQ-021 Pop accepted iff enb & pop & !pausa & !empty; accepted pop loads data_out from read pointer on the same edge and increments read pointer.
REQ-022 valid_out SHALL be 1 in the cycle after an accepted pop, else 0 (read latency 1 cycle).
REQ-023 data_out SHALL hold its last value when no pop is accepted.
REQ-024 Count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-025 Simultaneous push and pop when full: both accepted, count stays at depth, full stays 1, no error.
REQ-026 Simultaneous push and pop when empty: only push accepted (no bypass), count becomes 1, valid_out stays 0.
REQ-027 Push while full without accepted pop: word dropped, pointers/count unchanged, error_full set to 1 next cycle.
REQ-028 error_full SHALL remain 1 until rst.
REQ-029 Pop while empty or while pausa high: ignored, no state change, no error.
REQ-030 full, almost_full, empty, almost_empty SHALL be decoded from the registered count only (reflect state after the last edge, no combinational path from push/pop).
REQ-031 enb low: pointers, count, memory, data_out, error_full hold; valid_out forced to 0.
REQ-032 Pointer wrap from depth-1 to 0 SHALL be seamless; order of words SHALL be strictly FIFO.

Reset
REQ-033 On rst high at a rising edge (regardless of enb): pointers = 0, count = 0, data_out = 0, valid_out = 0, error_full = 0.
REQ-034 After reset: empty = 1, almost_empty = 1, full = 0, almost_full = 0.
REQ-035 Memory contents need not be cleared; reset mid-operation discards all stored words and any pending pop result.
REQ-036 rst takes priority over push, pop and enb in the same cycle.

Verification
REQ-037 Reset then 8 pushes of 1..8 -> almost_empty drops after 3rd push, almost_full rises after 6th, full = 1 after 8th, error_full = 0.
REQ-038 Full FIFO, one extra push of 9 -> count stays 8, error_full = 1 next cycle and stays 1; 8 pops return 1..8 with valid_out each cycle after pop.
REQ-039 Full FIFO, push 0x2A with pop same cycle -> data_out = oldest word next cycle, full stays 1; drain returns 0x2A last.
REQ-040 3 words stored, pausa = 1 with pop = 1 for 4 cycles -> no valid_out, count 3; pausa = 0 -> words emerge in order.
REQ-041 Empty FIFO, push 5 and pop same cycle -> count 1, valid_out = 0; following pop -> data_out = 5, valid_out = 1, empty = 1.
REQ-042 12 push/pop pairs through pointer wrap, then rst asserted with pop high -> next cycle valid_out = 0, empty = 1, error_full = 0.
